list_walk_sched: RTL and testbench
==================================

LIST_WALK_SCHED -- requirements
Module: list_walk_sched

Interface
REQ-001 SHALL have parameter N_PTR, default 16, meaning the number of next-pointer table entries.
REQ-002 SHALL have parameter W, default $clog2(N_PTR), meaning the pointer width.
REQ-003 SHALL have parameter NREQ, default 4, meaning the number of walk requesters.
REQ-004 SHALL have parameter LAT, default 3, meaning the table read latency in cycles.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have ports wr_vld (in, 1), wr_addr (in, W), wr_data (in, W) and wr_rdy (out, 1): table write channel, entry wr_addr := wr_data.
REQ-008 SHALL have ports req_vld (in, NREQ), req_ptr (in, NREQ*W) and req_rdy (out, NREQ): per-requester start pointer; slot i occupies bits [i*W +: W].
REQ-009 SHALL have ports out_vld (out, 1), out_ptr (out, W), out_id (out, $clog2(NREQ)) and out_last (out, 1): the traversed pointer stream.
REQ-010 SHALL have ports busy (out, 1), high whenever a walk is in progress, and err (out, 1), a loop-abort pulse.

Function
REQ-011 SHALL hold an N_PTR x W next-pointer table. Pointer 0 is the null terminator. Writes to address 0 are ignored.
REQ-012 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-013 SHALL assert wr_rdy only in IDLE. A write is accepted on wr_vld&&wr_rdy and is visible to reads from the next cycle.
REQ-014 SHALL let a write take priority in IDLE: no grant is made in a cycle in which a write is accepted.
REQ-015 SHALL arbitrate round-robin in IDLE, with wr_vld low, among requesters with req_vld high.
REQ-016 SHALL start the priority index at 0 after reset and set it to (i+1) mod NREQ after a grant to requester i.
REQ-017 SHALL pulse req_rdy[i] for one cycle on the grant cycle, and only there. It SHALL latch cur=req_ptr slot i and id=i.
REQ-018 SHALL handle a granted req_ptr==0 as follows: no output, walk retired, state stays IDLE.
REQ-019 SHALL otherwise go to ISSUE on a grant.
REQ-020 SHALL, in ISSUE, present read address cur to the table for 1 cycle, then go to WAIT for LAT cycles, counted by a down-counter.
REQ-021 SHALL, in the last WAIT cycle, drive out_vld=1, out_ptr=cur, out_id=id and out_last=(rdata==0), then set cur<=rdata.
REQ-022 SHALL then go to ISSUE if rdata!=0, else to IDLE.
REQ-023 SHALL deliver one element every LAT+1 cycles. The first out_vld SHALL occur LAT+1 cycles after the grant cycle.
REQ-024 SHALL hold busy=1 from the cycle after a non-null grant through the out_last cycle inclusive.
REQ-025 SHALL drive out_ptr, out_id and out_last to 0 whenever out_vld=0.
REQ-026 SHALL not abort a walk on deassertion of req_vld after grant. The walk completes.

Reset
REQ-027 SHALL, on rst, asynchronously set the state to IDLE, the priority index to 0, all table entries to 0, cur, id and the counters to 0, and every output except wr_rdy to 0.
REQ-028 SHALL drive wr_rdy to 1 during and after reset, since the FSM is in IDLE.
REQ-029 SHALL, on rst asserted mid-walk, discard the walk with no further out_vld, and not replay it after reset.

Configuration
REQ-030 SHALL, with macro LOOP_GUARD_EN defined, count the elements emitted in the current walk.
REQ-031 SHALL, under LOOP_GUARD_EN, when the N_PTR-th element is emitted with rdata!=0, force out_last=1, pulse err for that cycle and return to IDLE.
REQ-032 SHALL, without LOOP_GUARD_EN, have no element counter, tie err to 0, and continue a cyclic list indefinitely until reset.

Verification
REQ-033 SHALL cover: write 1->5, 5->3, 3->10, 10->0; req_vld[0], ptr 1 -> out_ptr 1,5,3,10 at grant+4, +8, +12, +16; id 0; out_last only on 10.
REQ-034 SHALL cover: req_vld[0] (ptr 2, list 2->4->0) and req_vld[2] (ptr 6, 6->0) raised together and held -> requester 0 walks first, then requester 2; then both raised again -> requester 2 granted before 0.
REQ-035 SHALL cover: req ptr 0 on requester 3 -> req_rdy[3] pulses, no out_vld, busy stays 0, and the next request is granted the following cycle.
REQ-036 SHALL cover: wr_vld and req_vld[1] both high in IDLE -> write accepted first, grant one cycle later; wr_vld during a walk -> wr_rdy=0 and the table is unchanged.
REQ-037 SHALL cover: list 7->15, 15->7 with LOOP_GUARD_EN -> 16 outputs alternating 7,15, with out_last and err on the 16th; without the macro -> outputs continue past 16 and err stays 0.
REQ-038 SHALL cover: rst asserted after the 2nd element of the REQ-033 walk -> out_vld and busy drop immediately, and the table reads all 0 afterwards.

Source files
------------

// File: rtl/list_walk_sched.sv
// Round-robin linked-list walker over an internal next-pointer table.
// Optional `LOOP_GUARD_EN` aborts walks longer than N_PTR elements with an err pulse.
module list_walk_sched #(
   parameter int N_PTR = 16,
   parameter int W     = $clog2(N_PTR),
   parameter int NREQ  = 4,
   parameter int LAT   = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_vld,
   input  logic [W-1:0]              wr_addr,
   input  logic [W-1:0]              wr_data,
   output logic                      wr_rdy,
   input  logic [NREQ-1:0]           req_vld,
   input  logic [NREQ*W-1:0]         req_ptr,
   output logic [NREQ-1:0]           req_rdy,
   output logic                      out_vld,
   output logic [W-1:0]              out_ptr,
   output logic [$clog2(NREQ)-1:0]   out_id,
   output logic                      out_last,
   output logic                      busy,
   output logic                      err
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t         r_state, w_state_nxt;
   logic [IW-1:0]  r_prio, r_id;
   logic [W-1:0]   r_cur, r_raddr;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_tbl [N_PTR];

   logic           w_any, w_can_gnt, w_wr_acc, w_last_wait, w_rnull, w_guard_hit, w_end;
   logic [IW-1:0]  w_gnt_idx;
   logic [W-1:0]   w_slot, w_rdata;

`ifdef LOOP_GUARD_EN
   localparam int EW = $clog2(N_PTR + 1);
   logic [EW-1:0]  r_elem;
   assign w_guard_hit = (r_elem == EW'(N_PTR - 1)) && !w_rnull;
`else
   assign w_guard_hit = 1'b0;
`endif

   // Scan from highest offset down so the lowest offset from r_prio wins.
   always_comb begin
      logic [IW-1:0] v_idx;
      w_any     = 1'b0;
      w_gnt_idx = '0;
      w_slot    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         v_idx = IW'((int'(r_prio) + k) % NREQ);
         if (req_vld[v_idx]) begin
            w_any     = 1'b1;
            w_gnt_idx = v_idx;
            w_slot    = req_ptr[v_idx*W +: W];
         end
      end
   end

   assign w_wr_acc    = wr_vld && (r_state == IDLE);
   assign w_can_gnt   = (r_state == IDLE) && !wr_vld && !rst && w_any;
   assign w_rdata     = r_tbl[r_raddr];
   assign w_rnull     = (w_rdata == '0);
   assign w_last_wait = (r_state == WAIT) && (r_cnt == '0);
   assign w_end       = w_rnull || w_guard_hit;

   always_comb begin
      w_state_nxt = r_state;
      req_rdy     = '0;
      unique case (r_state)
         IDLE: begin
            if (w_can_gnt) begin
               req_rdy = NREQ'(1) << w_gnt_idx;
               if (w_slot != '0) w_state_nxt = ISSUE;
            end
         end
         ISSUE: w_state_nxt = WAIT;
         WAIT: begin
            if (w_last_wait) w_state_nxt = w_end ? IDLE : ISSUE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign wr_rdy   = (r_state == IDLE);
   assign busy     = (r_state != IDLE);
   assign out_vld  = w_last_wait;
   assign out_ptr  = w_last_wait ? r_cur : '0;
   assign out_id   = w_last_wait ? r_id : '0;
   assign out_last = w_last_wait && w_end;
   assign err      = w_last_wait && w_guard_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_prio  <= '0;
         r_id    <= '0;
         r_cur   <= '0;
         r_raddr <= '0;
         r_cnt   <= '0;
         for (int i = 0; i < N_PTR; i++) r_tbl[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_wr_acc && (wr_addr != '0)) r_tbl[wr_addr] <= wr_data;
         if (w_can_gnt) begin
            r_prio <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_cur  <= w_slot;
            r_id   <= w_gnt_idx;
         end
         if (r_state == ISSUE) begin
            r_raddr <= r_cur;
            r_cnt   <= CW'(LAT - 1);
         end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_last_wait) r_cur <= w_rdata;
      end
   end

`ifdef LOOP_GUARD_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_elem <= '0;
      end else if (w_can_gnt) begin
         r_elem <= '0;
      end else if (w_last_wait) begin
         r_elem <= r_elem + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_list_walk_sched.sv
// Scoreboard bench for list_walk_sched: stimulus pushes expected elements, a monitor pops them.
module tb_list_walk_sched;
   localparam int W = 4;

   logic         clk, rst;
   logic         wr_vld, wr_rdy;
   logic [W-1:0] wr_addr, wr_data;
   logic [3:0]   req_vld, req_rdy;
   logic [15:0]  req_ptr;
   logic         out_vld, out_last, busy, err;
   logic [W-1:0] out_ptr;
   logic [1:0]   out_id;

   typedef struct {
      int ptr;
      int id;
      int last;
      int err;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;

   list_walk_sched dut (
      .clk      (clk),
      .rst      (rst),
      .wr_vld   (wr_vld),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_rdy   (wr_rdy),
      .req_vld  (req_vld),
      .req_ptr  (req_ptr),
      .req_rdy  (req_rdy),
      .out_vld  (out_vld),
      .out_ptr  (out_ptr),
      .out_id   (out_id),
      .out_last (out_last),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_chk);
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input int p, input int id, input int last, input int e, input int c);
      exp_t x;
      x.ptr = p; x.id = id; x.last = last; x.err = e; x.cyc = c;
      q.push_back(x);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input int p);
      req_vld[i]       = 1'b1;
      req_ptr[i*4 +: 4] = p[3:0];
   endtask

   task automatic wr(input int a, input int d);
      wr_vld  = 1'b1;
      wr_addr = a[3:0];
      wr_data = d[3:0];
      @(negedge clk);
      chk("wr_rdy_idle", wr_rdy, 1);
      tick();
      wr_vld = 1'b0;
   endtask

   task automatic wait_gnt(output int g, output int rdy);
      g   = -1;
      rdy = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_rdy != 4'b0) begin
            g   = cyc;
            rdy = req_rdy;
            return;
         end
      end
      chk("gnt_timeout", rdy, 1);
   endtask

   task automatic wait_idle(output int t);
      t = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk("idle_timeout", busy, 0);
      tick();
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Monitor: pops one expected element per out_vld; idle outputs must read zero.
   always @(negedge clk) begin
      exp_t e;
      if (out_vld) begin
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out: got out_ptr=%0d out_id=%0d, expected no output",
                     out_ptr, out_id);
         end else begin
            e = q.pop_front();
            chk("out_ptr", out_ptr, e.ptr);
            chk("out_id", out_id, e.id);
            chk("out_last", out_last, e.last);
            chk("out_err", err, e.err);
            if (e.cyc >= 0) chk("out_cycle", cyc, e.cyc);
         end
      end else begin
         chk("idle_outs", {out_ptr, out_id, out_last, err}, 0);
      end
   end

   initial begin
      int g, g2, t, rdy;
      rst = 1'b1; wr_vld = 1'b0; wr_addr = '0; wr_data = '0;
      req_vld = 4'b0001; req_ptr = 16'h0001;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_rdy", wr_rdy, 1);
      chk("rst_busy", busy, 0);
      chk("rst_req_rdy", req_rdy, 0);
      tick();
      req_vld = '0;
      rst     = 1'b0;

      wr(1, 5); wr(5, 3); wr(3, 10); wr(10, 0);
      wr(2, 4); wr(4, 0); wr(6, 0);

      // Round robin from priority 0: requester 0 then 2.
      set_req(0, 2); set_req(2, 6);
      wait_gnt(g, rdy);
      chk("rr1_first", rdy, 4'b0001);
      push(2, 0, 0, 0, g + 4); push(4, 0, 1, 0, g + 8);
      tick(); req_vld[0] = 1'b0;
      wait_gnt(g2, rdy);
      chk("rr1_second", rdy, 4'b0100);
      chk("rr1_second_cyc", g2, g + 9);
      push(6, 2, 1, 0, g2 + 4);
      tick(); req_vld[2] = 1'b0;
      wait_idle(t);

      // Basic four-element walk with fixed cadence.
      set_req(0, 1);
      wait_gnt(g, rdy);
      chk("walk_gnt", rdy, 4'b0001);
      push(1, 0, 0, 0, g + 4); push(5, 0, 0, 0, g + 8);
      push(3, 0, 0, 0, g + 12); push(10, 0, 1, 0, g + 16);
      tick(); req_vld[0] = 1'b0;
      @(negedge clk);
      chk("walk_busy", busy, 1);
      tick();
      wait_idle(t);
      chk("walk_end_cyc", t, g + 17);

      // Priority now 1: requester 2 ahead of 0.
      set_req(0, 2); set_req(2, 6);
      wait_gnt(g, rdy);
      chk("rr2_first", rdy, 4'b0100);
      push(6, 2, 1, 0, g + 4);
      tick(); req_vld[2] = 1'b0;
      wait_gnt(g2, rdy);
      chk("rr2_second", rdy, 4'b0001);
      chk("rr2_second_cyc", g2, g + 5);
      push(2, 0, 0, 0, g2 + 4); push(4, 0, 1, 0, g2 + 8);
      tick(); req_vld[0] = 1'b0;
      wait_idle(t);

      // Null start pointer retires at once.
      set_req(3, 0);
      wait_gnt(g, rdy);
      chk("null_gnt", rdy, 4'b1000);
      chk("null_busy", busy, 0);
      tick(); req_vld[3] = 1'b0; set_req(0, 6);
      @(negedge clk);
      chk("null_next_gnt", req_rdy, 4'b0001);
      chk("null_next_cyc", cyc, g + 1);
      chk("null_busy_after", busy, 0);
      push(6, 0, 1, 0, cyc + 4);
      tick(); req_vld[0] = 1'b0;
      wait_idle(t);

      // Write beats grant; writes blocked mid-walk.
      wr_vld = 1'b1; wr_addr = 4'd8; wr_data = 4'd11;
      set_req(1, 8);
      @(negedge clk);
      chk("wr_prio_wr_rdy", wr_rdy, 1);
      chk("wr_prio_no_gnt", req_rdy, 0);
      tick(); wr_vld = 1'b0;
      @(negedge clk);
      chk("wr_prio_gnt", req_rdy, 4'b0010);
      g = cyc;
      push(8, 1, 0, 0, g + 4); push(11, 1, 1, 0, g + 8);
      tick(); req_vld[1] = 1'b0;
      wr_vld = 1'b1; wr_addr = 4'd11; wr_data = 4'd3;
      @(negedge clk);
      chk("wr_blocked", wr_rdy, 0);
      tick(); wr_vld = 1'b0;
      wait_idle(t);

      // Reset mid-walk after the second element.
      set_req(0, 1);
      wait_gnt(g, rdy);
      chk("rstwalk_gnt", rdy, 4'b0001);
      push(1, 0, 0, 0, g + 4); push(5, 0, 0, 0, g + 8);
      tick(); req_vld[0] = 1'b0;
      wait_cyc(g + 8);
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_out_vld", out_vld, 0);
      chk("rst_mid_wr_rdy", wr_rdy, 1);
      chk("rst_mid_drain", q.size(), 0);
      tick(); tick();
      rst = 1'b0;
      repeat (20) tick();
      // Table cleared and priority back to 0.
      set_req(0, 1); set_req(1, 5);
      wait_gnt(g, rdy);
      chk("post_rst_gnt", rdy, 4'b0001);
      push(1, 0, 1, 0, g + 4);
      tick(); req_vld[0] = 1'b0;
      wait_gnt(g2, rdy);
      chk("post_rst_gnt2", rdy, 4'b0010);
      chk("post_rst_gnt2_cyc", g2, g + 5);
      push(5, 1, 1, 0, g2 + 4);
      tick(); req_vld[1] = 1'b0;
      wait_idle(t);
      chk("post_rst_drain", q.size(), 0);

      // Cyclic list 7 <-> 15.
      wr(7, 15); wr(15, 7);
      set_req(2, 7);
      wait_gnt(g, rdy);
      chk("loop_gnt", rdy, 4'b0100);
`ifdef LOOP_GUARD_EN
      for (int k = 1; k <= 16; k++)
         push((k % 2 == 1) ? 7 : 15, 2, (k == 16) ? 1 : 0, (k == 16) ? 1 : 0, g + 4 * k);
      tick(); req_vld[2] = 1'b0;
      wait_idle(t);
      chk("loop_abort_cyc", t, g + 65);
      repeat (10) tick();
`else
      for (int k = 1; k <= 20; k++)
         push((k % 2 == 1) ? 7 : 15, 2, 0, 0, g + 4 * k);
      tick(); req_vld[2] = 1'b0;
      wait_cyc(g + 80);
      tick();
      chk("loop_still_busy", busy, 1);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      repeat (10) tick();
`endif
      chk("final_drain", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
